seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Mealy serial-pattern detector, the next generation of the team's fixed 4-state "1011" detector.
- Pattern length and reset pattern are generics. The pattern can also be reloaded at runtime.
- Supports overlapping and non-overlapping match modes, a clock enable, a registered match copy and a saturating match counter.
- Sits on a serial bit stream (frame-sync / marker search) and flags each occurrence of the pattern.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, reset value of the pattern register; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  bit-valid; d_in is sampled only when en=1.
- d_in  in  1  serial data bit.
- overlap  in  1  1 = overlapping matches allowed; 0 = history flushed after each match.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_LEN  new pattern; MSB is first bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  Mealy match, combinational from state and current inputs.
- match_q  out  1  match registered one cycle later.
- match_cnt  out  CNT_W  count of matches, saturating.

Behaviour:
- Reset (async, reset=1):
  - pat_reg = PATTERN.
  - hist (PAT_LEN-1 bits) = 0.
  - fill = 0.
  - match_q = 0.
  - match_cnt = 0.
  - match = 0 while reset is held.
- State:
  - hist holds the last PAT_LEN-1 accepted bits; newest is the LSB.
  - fill counts accepted bits, saturating at PAT_LEN-1.
  - Only bits accepted since the last flush count toward a match. Stale hist contents never match.
- match = en & ~pat_load & (fill == PAT_LEN-1) & ({hist, d_in} == pat_reg). Zero latency: asserts in the same cycle as the last pattern bit.
- Clock edge with pat_load=1 (pat_load has priority over en):
  - pat_reg <= pat_in.
  - fill <= 0; hist <= 0.
  - No match is reported in this cycle.
  - match_cnt is unaffected.
- Clock edge with en=1 and pat_load=0:
  - hist <= {hist[PAT_LEN-3:0], d_in}, i.e. shift left and insert d_in.
  - fill <= min(fill+1, PAT_LEN-1).
  - If match=1 and overlap=0: fill <= 0 and hist <= 0.
- Clock edge with en=0:
  - hist and fill hold.
  - A gap in en does not break a partial match.
- match_q <= match on every clock edge.
- match_cnt, per clock edge:
  - If cnt_clr=1: 0. cnt_clr wins over a simultaneous match.
  - Else if match=1 and match_cnt < 2^CNT_W-1: +1.
  - Otherwise hold; the counter saturates at all-ones with no wrap.
- overlap may change on any cycle. It takes effect on the edge where it is sampled together with a match.
- Reset mid-pattern discards partial history; the pattern must be received in full again.
- Pattern register content is arbitrary, including all-zeros and all-ones. An all-ones pattern with overlap=1 matches on every accepted 1 once fill is saturated.

Test Plan:
- Overlap mode: defaults, overlap=1, en=1, d_in = 1,0,1,1,0,1,1 -> match=1 on bits 4 and 7 only; match_q follows one cycle later; match_cnt=2.
- Non-overlap mode: same stream with overlap=0 -> match on bit 4 only; match_cnt=1. Then stream 1,0,1,1 -> match on its 4th bit; match_cnt=2.
- en gaps: bits 1,0 then en=0 for 3 cycles with d_in toggling, then 1,1 -> match on the final bit; no match during the gap.
- Reset mid-pattern: 1,0,1, then pulse reset between clock edges, then 1 -> no match; match_cnt=0. Then 0,1,1,... -> match only after a full 1,0,1,1 following reset.
- Runtime reload: pat_load with pat_in=4'b0110 asserted while d_in=1 -> no match that cycle. Then 0,1,1,0 -> match on the 4th bit. Then 1,0,1,1 -> no match.
- Counter: CNT_W=2, overlap=1, stream 1011 repeated 5 times -> match_cnt saturates at 3. Then cnt_clr asserted in the same cycle as a match -> match_cnt=0.

Source files
------------

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module  : seq_detector_param
// Brief   : Parametrised Mealy serial-pattern detector with runtime reload,
//           overlap control, registered match copy and saturating counter.
// Rev     : 1.0  initial release
// ============================================================================
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               d_in,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int                 FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;

  // Candidate window: accepted history plus the bit on the wire this cycle.
  assign window = {hist, d_in};

  // fill gates out stale history, so a match needs PAT_LEN fresh bits.
  assign match = en & ~pat_load & (fill == FILL_MAX) & (window == pat_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_reg   <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_q <= match;

      if (cnt_clr)
        match_cnt <= '0;
      else if (match && (match_cnt != CNT_MAX))
        match_cnt <= match_cnt + 1'b1;

      if (pat_load) begin
        pat_reg <= pat_in;
        hist    <= '0;
        fill    <= '0;
      end else if (en) begin
        if (match && !overlap) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= window[PAT_LEN-2:0];
          if (fill != FILL_MAX)
            fill <= fill + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_detector_param
// Brief   : Directed self-checking bench for seq_detector_param.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       d_in;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;
  logic       match;
  logic       match_q;
  logic [7:0] match_cnt;
  logic       match2;
  logic       match_q2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .d_in(d_in), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match), .match_q(match_q), .match_cnt(match_cnt)
  );

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .d_in(d_in), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match2), .match_q(match_q2), .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one bit, check Mealy match mid-cycle, then match_q after the edge.
  task automatic bit_in(input logic e, input logic d, input logic exp_m, input string tag);
    en   = e;
    d_in = d;
    @(negedge clk);
    chk({tag, ".match"}, {31'd0, match}, {31'd0, exp_m});
    @(posedge clk);
    #1;
    chk({tag, ".match_q"}, {31'd0, match_q}, {31'd0, exp_m});
  endtask

  task automatic do_reset();
    en = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    d_in     = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_in   = 4'b0000;
    cnt_clr  = 1'b0;
    #1;
    chk("rst.match",   {31'd0, match},     32'd0);
    chk("rst.match_q", {31'd0, match_q},   32'd0);
    chk("rst.cnt",     {24'd0, match_cnt}, 32'd0);
    #11;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Overlapping matches on 1,0,1,1,0,1,1
    overlap = 1'b1;
    bit_in(1, 1, 0, "ov1");
    bit_in(1, 0, 0, "ov2");
    bit_in(1, 1, 0, "ov3");
    bit_in(1, 1, 1, "ov4");
    bit_in(1, 0, 0, "ov5");
    bit_in(1, 1, 0, "ov6");
    bit_in(1, 1, 1, "ov7");
    chk("ov.cnt", {24'd0, match_cnt}, 32'd2);

    // Non-overlapping: history flushed after each match
    do_reset();
    overlap = 1'b0;
    bit_in(1, 1, 0, "no1");
    bit_in(1, 0, 0, "no2");
    bit_in(1, 1, 0, "no3");
    bit_in(1, 1, 1, "no4");
    bit_in(1, 0, 0, "no5");
    bit_in(1, 1, 0, "no6");
    bit_in(1, 1, 0, "no7");
    chk("no.cnt1", {24'd0, match_cnt}, 32'd1);
    bit_in(1, 1, 0, "no8");
    bit_in(1, 0, 0, "no9");
    bit_in(1, 1, 0, "no10");
    bit_in(1, 1, 1, "no11");
    chk("no.cnt2", {24'd0, match_cnt}, 32'd2);

    // en gaps keep the partial match
    do_reset();
    overlap = 1'b1;
    bit_in(1, 1, 0, "gap1");
    bit_in(1, 0, 0, "gap2");
    bit_in(0, 1, 0, "gap3");
    bit_in(0, 0, 0, "gap4");
    bit_in(0, 1, 0, "gap5");
    bit_in(1, 1, 0, "gap6");
    bit_in(1, 1, 1, "gap7");
    chk("gap.cnt", {24'd0, match_cnt}, 32'd1);

    // Reset mid-pattern: history left as 101 would otherwise match on the next 1
    bit_in(1, 1, 0, "mr1");
    bit_in(1, 0, 0, "mr2");
    bit_in(1, 1, 0, "mr3");
    reset = 1'b1;
    #2;
    chk("mr.cnt_rst", {24'd0, match_cnt}, 32'd0);
    chk("mr.match_rst", {31'd0, match}, 32'd0);
    reset = 1'b0;
    bit_in(1, 1, 0, "mr4");
    chk("mr.cnt0", {24'd0, match_cnt}, 32'd0);
    bit_in(1, 0, 0, "mr5");
    bit_in(1, 1, 0, "mr6");
    bit_in(1, 1, 1, "mr7");
    chk("mr.cnt1", {24'd0, match_cnt}, 32'd1);

    // Runtime reload while the old pattern would complete
    bit_in(1, 1, 0, "ld1");
    bit_in(1, 0, 0, "ld2");
    bit_in(1, 1, 0, "ld3");
    pat_load = 1'b1;
    pat_in   = 4'b0110;
    bit_in(1, 1, 0, "ld_load");
    pat_load = 1'b0;
    chk("ld.cnt_hold", {24'd0, match_cnt}, 32'd1);
    bit_in(1, 0, 0, "ld4");
    bit_in(1, 1, 0, "ld5");
    bit_in(1, 1, 0, "ld6");
    bit_in(1, 0, 1, "ld7");
    bit_in(1, 1, 0, "ld8");
    bit_in(1, 0, 0, "ld9");
    bit_in(1, 1, 0, "ld10");
    bit_in(1, 1, 0, "ld11");
    chk("ld.cnt", {24'd0, match_cnt}, 32'd2);

    // Saturation on the 2-bit counter instance
    do_reset();
    overlap = 1'b1;
    for (int r = 0; r < 5; r++) begin
      bit_in(1, 1, 0, "sat_a");
      bit_in(1, 0, 0, "sat_b");
      bit_in(1, 1, 0, "sat_c");
      bit_in(1, 1, 1, "sat_d");
    end
    chk("sat.cnt2", {30'd0, match_cnt2}, 32'd3);
    chk("sat.cnt8", {24'd0, match_cnt},  32'd5);
    chk("sat.match_q2", {31'd0, match_q2}, 32'd1);

    // cnt_clr beats a simultaneous match
    bit_in(1, 1, 0, "clr1");
    bit_in(1, 0, 0, "clr2");
    bit_in(1, 1, 0, "clr3");
    cnt_clr = 1'b1;
    bit_in(1, 1, 1, "clr4");
    cnt_clr = 1'b0;
    chk("clr.cnt2", {30'd0, match_cnt2}, 32'd0);
    chk("clr.cnt8", {24'd0, match_cnt},  32'd0);
    chk("clr.match2", {31'd0, match2},   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
